// File: rtl/response_serializer.sv
// Purpose : serialise one response frame, MSB byte first, onto the UART TX handshake.
// Latency : first o_Tx_DV one clock after accept; each later byte two clocks after i_Tx_Done.
// Backpr. : one frame in flight at a time, so o_Frame_Ready is low until the frame ends.
//           Each byte waits in SEND while i_Tx_Active is high.
//           A byte with no i_Tx_Done after TIMEOUT_CYCLES clocks aborts the frame.
//
// Ports
//   i_Clock / i_Reset              clock, asynchronous active-high reset
//   i_Frame / i_Frame_Valid        frame request; frame captured when o_Frame_Ready is high
//   o_Frame_Ready / o_Busy         decoded from state: ready in IDLE only, busy otherwise
//   o_Tx_DV / o_Tx_Byte            one-cycle load strobe and byte to the UART transmitter
//   i_Tx_Active / i_Tx_Done        transmitter busy level and byte-finished pulse
//   o_Frame_Sent / o_Error         one-cycle pulses: frame completed / frame aborted
module response_serializer #(
    parameter int FRAME_BYTES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic [8*FRAME_BYTES-1:0] i_Frame,
    input  logic                     i_Frame_Valid,
    output logic                     o_Frame_Ready,
    output logic                     o_Tx_DV,
    output logic [7:0]               o_Tx_Byte,
    input  logic                     i_Tx_Active,
    input  logic                     i_Tx_Done,
    output logic                     o_Frame_Sent,
    output logic                     o_Error,
    output logic                     o_Busy
);

    localparam int FW    = 8 * FRAME_BYTES;
    // A one-byte frame still needs a 1-bit index register.
    localparam int IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q,   state_d;
    logic [FW-1:0]    shift_q,   shift_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             tx_dv_q,   tx_dv_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             sent_q,    sent_d;
    logic             err_q,     err_d;

    // State and registered outputs
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            sent_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            sent_q    <= sent_d;
            err_q     <= err_d;
        end
    end

    // Next state. The strobes tx_dv/sent/err are computed on the transition,
    // so each one is high during the first cycle of the following state.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
        sent_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // i_Tx_Done is deliberately ignored here.
                if (i_Frame_Valid) begin
                    shift_d = i_Frame;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                if (!i_Tx_Active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = shift_q[FW-1 -: 8];
                    cnt_d     = '0;
                    state_d   = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // The counter saturates rather than wrapping.
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                // i_Tx_Done is tested first, so it wins over a same-cycle timeout.
                if (i_Tx_Done) begin
                    if (idx_q == LAST_IDX) begin
                        sent_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        shift_d = shift_q << 8;
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SEND;
                    end
                end else if (cnt_q == CNT_TERM) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_Frame_Ready = (state_q == ST_IDLE);
    assign o_Busy        = (state_q != ST_IDLE);
    assign o_Tx_DV       = tx_dv_q;
    assign o_Tx_Byte     = tx_byte_q;
    assign o_Frame_Sent  = sent_q;
    assign o_Error       = err_q;

endmodule

// File: tb/tb_response_serializer.sv
// Purpose : self-checking bench for response_serializer (2-byte frames, 16-clock timeout).
// Latency : the reference model predicts every output for every clock.
// Backpr. : the bench producer holds i_Frame_Valid until the frame is accepted.
module tb_response_serializer;

    localparam int FB = 2;
    localparam int TO = 16;

    logic          i_Clock = 1'b0;
    logic          i_Reset = 1'b1;
    logic [15:0]   i_Frame = 16'h0000;
    logic          i_Frame_Valid = 1'b0;
    logic          o_Frame_Ready;
    logic          o_Tx_DV;
    logic [7:0]    o_Tx_Byte;
    logic          i_Tx_Active = 1'b0;
    logic          i_Tx_Done = 1'b0;
    logic          o_Frame_Sent;
    logic          o_Error;
    logic          o_Busy;

    response_serializer #(.FRAME_BYTES(FB), .TIMEOUT_CYCLES(TO)) dut (
        .i_Clock       (i_Clock),
        .i_Reset       (i_Reset),
        .i_Frame       (i_Frame),
        .i_Frame_Valid (i_Frame_Valid),
        .o_Frame_Ready (o_Frame_Ready),
        .o_Tx_DV       (o_Tx_DV),
        .o_Tx_Byte     (o_Tx_Byte),
        .i_Tx_Active   (i_Tx_Active),
        .i_Tx_Done     (i_Tx_Done),
        .o_Frame_Sent  (o_Frame_Sent),
        .o_Error       (o_Error),
        .o_Busy        (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The frame is held as a queue of bytes still to be sent.
    // Timeout rule: an error fires TO clocks after o_Tx_DV if no i_Tx_Done has been seen.
    int         cyc = 0;
    logic [7:0] mq[$];
    bit         m_idle = 1'b1, m_load = 1'b0, m_wait = 1'b0, m_fin = 1'b0;
    int         dv_at = 0;
    int         m_acc = 0;
    logic       e_dv = 1'b0, e_sent = 1'b0, e_err = 1'b0;
    logic [7:0] e_byte = 8'h00;

    always @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            m_idle = 1'b1; m_load = 1'b0; m_wait = 1'b0; m_fin = 1'b0;
            mq.delete();
            e_dv = 1'b0; e_sent = 1'b0; e_err = 1'b0; e_byte = 8'h00;
        end else begin
            cyc++;
            e_dv = 1'b0; e_sent = 1'b0; e_err = 1'b0;
            if (m_idle) begin
                if (i_Frame_Valid) begin
                    mq.delete();
                    for (int b = 0; b < FB; b++) mq.push_back(i_Frame[8*(FB-1-b) +: 8]);
                    m_idle = 1'b0; m_load = 1'b1; m_acc++;
                end
            end else if (m_load) begin
                if (!i_Tx_Active) begin
                    e_dv = 1'b1; e_byte = mq[0];
                    m_load = 1'b0; m_wait = 1'b1; dv_at = cyc;
                end
            end else if (m_wait) begin
                if (i_Tx_Done) begin
                    void'(mq.pop_front());
                    m_wait = 1'b0;
                    if (mq.size() == 0) begin
                        e_sent = 1'b1; m_fin = 1'b1;
                    end else begin
                        m_load = 1'b1;
                    end
                end else if (cyc - dv_at == TO) begin
                    e_err = 1'b1; m_wait = 1'b0; m_idle = 1'b1; mq.delete();
                end
            end else if (m_fin) begin
                m_fin = 1'b0; m_idle = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare and event logs ----------------
    int         dv_cyc[$];
    logic [7:0] dv_byte[$];
    int         sent_cyc[$];
    int         err_cyc[$];
    logic       err_rdy[$];

    always @(negedge i_Clock) begin
        if (!i_Reset && chk_on) begin
            chk("tx_dv",       int'(o_Tx_DV),       int'(e_dv));
            chk("tx_byte",     int'(o_Tx_Byte),     int'(e_byte));
            chk("frame_sent",  int'(o_Frame_Sent),  int'(e_sent));
            chk("error",       int'(o_Error),       int'(e_err));
            chk("busy",        int'(o_Busy),        int'(!m_idle));
            chk("frame_ready", int'(o_Frame_Ready), int'(m_idle));
            if (o_Tx_DV) begin
                dv_cyc.push_back(cyc);
                dv_byte.push_back(o_Tx_Byte);
            end
            if (o_Frame_Sent) sent_cyc.push_back(cyc);
            if (o_Error) begin
                err_cyc.push_back(cyc);
                err_rdy.push_back(o_Frame_Ready);
            end
        end
    end

    // ---------------- stimulus: producer and UART TX responder ----------------
    bit pend_acc = 1'b0;
    bit b2b = 1'b0;
    int gap = 0;
    int n_acc = 0;
    int acc_edge = 0;
    bit auto_resp = 1'b0;
    int dly_lo = 10, dly_hi = 10;
    int tx_cnt = 0;
    int hold_act = 0;
    int fall_cyc = 0;

    task automatic eval_acc();
        if (i_Frame_Valid && o_Frame_Ready) begin
            pend_acc = 1'b1;
            acc_edge = cyc + 1;
        end
    endtask

    task automatic present(input logic [15:0] f);
        i_Frame = f;
        i_Frame_Valid = 1'b1;
        eval_acc();
    endtask

    task automatic tick();
        @(negedge i_Clock);
        i_Tx_Done = 1'b0;
        if (pend_acc) begin
            pend_acc = 1'b0;
            n_acc++;
            if (b2b && $urandom_range(3, 0) != 0) begin
                i_Frame = 16'($urandom);
            end else begin
                i_Frame_Valid = 1'b0;
                i_Frame = 16'($urandom);
                gap = b2b ? int'($urandom_range(6, 1)) : 0;
            end
        end else if (b2b && !i_Frame_Valid) begin
            if (gap > 0) gap--;
            else begin
                i_Frame_Valid = 1'b1;
                i_Frame = 16'($urandom);
            end
        end
        eval_acc();
        if (auto_resp) begin
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    i_Tx_Done = 1'b1;
                    i_Tx_Active = 1'b0;
                end
            end
            if (o_Tx_DV) begin
                i_Tx_Active = 1'b1;
                tx_cnt = int'($urandom_range(dly_hi, dly_lo));
            end
        end
        if (b2b && hold_act == 0 && $urandom_range(15, 0) == 0) hold_act = int'($urandom_range(5, 1));
        if (hold_act > 0) begin
            i_Tx_Active = 1'b1;
            hold_act--;
            if (hold_act == 0) begin
                i_Tx_Active = 1'b0;
                fall_cyc = cyc;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_logs();
        #1;
        dv_cyc.delete(); dv_byte.delete(); sent_cyc.delete();
        err_cyc.delete(); err_rdy.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dv"},    int'(o_Tx_DV),       0);
        chk({tag, "_byte"},  int'(o_Tx_Byte),     0);
        chk({tag, "_sent"},  int'(o_Frame_Sent),  0);
        chk({tag, "_err"},   int'(o_Error),       0);
        chk({tag, "_busy"},  int'(o_Busy),        0);
        chk({tag, "_ready"}, int'(o_Frame_Ready), 1);
    endtask

    initial begin
        // ---- power-on reset ----
        @(negedge i_Clock);
        chk_reset_outputs("por");
        repeat (2) @(negedge i_Clock);
        #2 i_Reset = 1'b0;
        chk_on = 1'b1;
        run(2);

        // ---- frame A53C, TX idle, Done 10 clocks after each DV ----
        auto_resp = 1'b1; dly_lo = 10; dly_hi = 10; tx_cnt = 0;
        clear_logs();
        present(16'hA53C);
        run(40);
        chk("t1_dv_count",  dv_byte.size(), 2);
        chk("t1_byte0",     int'(dv_byte[0]), 'hA5);
        chk("t1_byte1",     int'(dv_byte[1]), 'h3C);
        chk("t1_first_lat", dv_cyc[0] - acc_edge, 1);
        chk("t1_byte_gap",  dv_cyc[1] - dv_cyc[0], 12);
        chk("t1_sent_cnt",  sent_cyc.size(), 1);
        chk("t1_sent_lat",  sent_cyc[0] - dv_cyc[1], 11);
        chk("t1_err_cnt",   err_cyc.size(), 0);

        // ---- TX busy for 20 clocks at accept ----
        clear_logs();
        present(16'hA55A);
        i_Tx_Active = 1'b1;
        hold_act = 20;
        run(60);
        chk("t2_dv_after_fall", dv_cyc[0] - fall_cyc, 1);
        chk("t2_byte0",         int'(dv_byte[0]), 'hA5);
        chk("t2_byte1",         int'(dv_byte[1]), 'h5A);
        chk("t2_sent_cnt",      sent_cyc.size(), 1);

        // ---- no Done after first DV: timeout ----
        auto_resp = 1'b0; tx_cnt = 0;
        clear_logs();
        present(16'hC3E1);
        run(40);
        chk("t3_dv_count",  dv_byte.size(), 1);
        chk("t3_byte0",     int'(dv_byte[0]), 'hC3);
        chk("t3_err_cnt",   err_cyc.size(), 1);
        chk("t3_err_lat",   err_cyc[0] - dv_cyc[0], 16);
        chk("t3_err_ready", int'(err_rdy[0]), 1);
        chk("t3_sent_cnt",  sent_cyc.size(), 0);

        // ---- Done on the timeout terminal cycle ----
        clear_logs();
        present(16'h5AF0);
        for (int k = 0; k < 10 && !o_Tx_DV; k++) tick();
        chk("t4_dv_seen", int'(o_Tx_DV), 1);
        run(15);
        i_Tx_Done = 1'b1;
        auto_resp = 1'b1; dly_lo = 3; dly_hi = 3; tx_cnt = 0;
        run(30);
        chk("t4_err_cnt",  err_cyc.size(), 0);
        chk("t4_dv_count", dv_byte.size(), 2);
        chk("t4_byte1",    int'(dv_byte[1]), 'hF0);
        chk("t4_gap",      dv_cyc[1] - dv_cyc[0], 17);
        chk("t4_sent_cnt", sent_cyc.size(), 1);

        // ---- reset while byte 0 is in flight ----
        auto_resp = 1'b0; tx_cnt = 0;
        clear_logs();
        present(16'h1234);
        for (int k = 0; k < 10 && !o_Tx_DV; k++) tick();
        chk("t5_dv_before_rst", int'(o_Tx_DV), 1);
        #2 i_Reset = 1'b1;
        #1 chk_reset_outputs("t5_rst");
        pend_acc = 1'b0; i_Frame_Valid = 1'b0; i_Tx_Active = 1'b0;
        tick();
        #2 i_Reset = 1'b0;
        clear_logs();
        run(20);
        chk("t5_no_err",  err_cyc.size(), 0);
        chk("t5_no_sent", sent_cyc.size(), 0);
        auto_resp = 1'b1; dly_lo = 3; dly_hi = 3; tx_cnt = 0;
        clear_logs();
        present(16'h0102);
        run(40);
        chk("t5_byte0",    int'(dv_byte[0]), 'h01);
        chk("t5_byte1",    int'(dv_byte[1]), 'h02);
        chk("t5_sent_cnt", sent_cyc.size(), 1);

        // ---- randomised back-to-back traffic, random TX delays incl. timeouts ----
        n_acc = 0; m_acc = 0;
        dly_lo = 1; dly_hi = 19;
        b2b = 1'b1; gap = 0;
        run(3000);
        b2b = 1'b0; hold_act = 0;
        run(80);
        chk("rand_accept_count", n_acc, m_acc);
        chk("rand_progress", int'(n_acc > 50), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
